spi_cmd_bridge: RTL and testbench

- Word-level command/data bridge between the SPI slave word interface (done/din/dout) and N_CH packet FIFOs plus a control register.
- Parametrised successor to the single-FIFO, hard-coded command SPI test top.
- First word of each SS-low transaction is a command; subsequent words stream FIFO data out, status out, or control data in.
- Sits in the top level between spi_slave and the per-front-end packet FIFOs; drives the buzzer/debug control bits.

---
 rtl/spi_bridge_pkg.sv | 28 ++
 rtl/spi_rdmux.sv | 55 +++++
 rtl/spi_cmd_bridge.sv | 196 +++++++++++++++++++
 tb/tb_spi_cmd_bridge.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
//-----------------------------------------------------------------------------
// Module   : spi_bridge_pkg
// Brief    : Opcodes, FSM state encoding and default response words for
//            the SPI command bridge.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

package spi_bridge_pkg;

    localparam logic [7:0]  c_op_fifo_rd = 8'h01;
    localparam logic [7:0]  c_op_status  = 8'h02;
    localparam logic [7:0]  c_op_ctrl_wr = 8'h03;
    localparam logic [7:0]  c_op_idle    = 8'hFF;

    localparam logic [15:0] c_cmd_idle   = 16'hFFFF;
    localparam logic [15:0] c_empty_word = 16'hFFFF;
    localparam logic [15:0] c_err_word   = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_rdmux.sv
//-----------------------------------------------------------------------------
// Module   : spi_rdmux
// Brief    : Registered channel select over the packet FIFO heads with a
//            bounds check; a load bypasses the register in the same clk.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module spi_rdmux
    import spi_bridge_pkg::*;
#(
    parameter int DW   = 16,
    parameter int N_CH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ch_load,
    input  logic [7:0]           ch_in,
    input  logic [N_CH-1:0]      fifo_empty,
    input  logic [N_CH*DW-1:0]   fifo_rdata,
    output logic                 sel_valid,
    output logic [DW-1:0]        sel_data,
    output logic [N_CH-1:0]      sel_onehot
);

    logic [7:0] ch_q;
    logic [7:0] ch_d;

    assign ch_d = ch_load ? ch_in : ch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= 8'hFF;
        end else begin
            ch_q <= ch_d;
        end
    end

    // Out-of-range channels match no loop index and fall through as invalid.
    always_comb begin
        sel_valid  = 1'b0;
        sel_data   = '0;
        sel_onehot = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_d == 8'(k)) begin
                sel_data      = fifo_rdata[k*DW +: DW];
                sel_valid     = ~fifo_empty[k];
                sel_onehot[k] = ~fifo_empty[k];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_cmd_bridge.sv
//-----------------------------------------------------------------------------
// Module   : spi_cmd_bridge
// Brief    : Word-level SPI command bridge to N_CH packet FIFOs and a control
//            register. Build option SPI_BRIDGE_POPCNT_EN adds a pop counter.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module spi_cmd_bridge
    import spi_bridge_pkg::*;
#(
    parameter int            DW         = 16,
    parameter int            N_CH       = 2,
    parameter logic [DW-1:0] EMPTY_WORD = c_empty_word,
    parameter logic [DW-1:0] ERR_WORD   = c_err_word
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ss,
    input  logic                 spi_done,
    input  logic [DW-1:0]        rx_data,
    output logic [DW-1:0]        tx_data,
    input  logic [N_CH-1:0]      fifo_empty,
    input  logic [N_CH*DW-1:0]   fifo_rdata,
    output logic [N_CH-1:0]      fifo_re,
    output logic [DW-1:0]        ctrl,
    output logic                 busy
);

    state_t          state_q, state_d;
    logic [15:0]     cmd_q, cmd_d;
    logic [DW-1:0]   tx_q, tx_d;
    logic [DW-1:0]   ctrl_q, ctrl_d;
    logic [N_CH-1:0] fifo_re_q, fifo_re_d;
    logic [1:0]      data_cnt_q, data_cnt_d;
    logic            done_q, ss_prev_q, busy_q;

    logic            done_rise, respond, first_word, ch_load, sel_valid;
    logic [7:0]      opcode;
    logic [DW-1:0]   sel_data, status_w2;
    logic [N_CH-1:0] sel_onehot;

    assign done_rise  = spi_done & ~done_q;
    assign first_word = (state_q == ST_CMD);
    assign respond    = done_rise & ~ss & (state_q != ST_IDLE);
    assign ch_load    = respond & first_word;
    // The command word is still on rx_data while it is being decoded.
    assign opcode     = first_word ? rx_data[15:8] : cmd_q[15:8];

    spi_rdmux #(
        .DW   (DW),
        .N_CH (N_CH)
    ) u_rdmux (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_load    (ch_load),
        .ch_in      (rx_data[7:0]),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .sel_valid  (sel_valid),
        .sel_data   (sel_data),
        .sel_onehot (sel_onehot)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        tx_d       = tx_q;
        ctrl_d     = ctrl_q;
        fifo_re_d  = '0;
        data_cnt_d = data_cnt_q;

        case (state_q)
            ST_IDLE: begin
                cmd_d      = c_cmd_idle;
                tx_d       = EMPTY_WORD;
                data_cnt_d = '0;
                // Require a fresh ss fall so a reset mid-transaction cannot resync onto data.
                if (!ss && ss_prev_q) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (respond) begin
                    cmd_d   = rx_data[15:0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (respond && data_cnt_q != 2'd2) begin
                    data_cnt_d = data_cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (respond) begin
            case (opcode)
                c_op_fifo_rd: begin
                    if (sel_valid) begin
                        tx_d      = sel_data;
                        fifo_re_d = sel_onehot;
                    end else begin
                        tx_d = EMPTY_WORD;
                    end
                end
                c_op_status: begin
                    tx_d = '0;
                    if (first_word) begin
                        tx_d[N_CH-1:0] = fifo_empty;
                    end else if (data_cnt_q == 2'd0) begin
                        tx_d = status_w2;
                    end
                end
                c_op_ctrl_wr: begin
                    if (!first_word && data_cnt_q == 2'd0) begin
                        ctrl_d = rx_data;
                        tx_d   = rx_data;
                    end else begin
                        tx_d = ctrl_q;
                    end
                end
                c_op_idle: tx_d = EMPTY_WORD;
                default:   tx_d = ERR_WORD;
            endcase
        end

        if (ss) begin
            state_d    = ST_IDLE;
            cmd_d      = c_cmd_idle;
            tx_d       = EMPTY_WORD;
            data_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= c_cmd_idle;
            tx_q       <= EMPTY_WORD;
            ctrl_q     <= '0;
            fifo_re_q  <= '0;
            data_cnt_q <= '0;
            done_q     <= 1'b0;
            ss_prev_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            tx_q       <= tx_d;
            ctrl_q     <= ctrl_d;
            fifo_re_q  <= fifo_re_d;
            data_cnt_q <= data_cnt_d;
            done_q     <= spi_done;
            ss_prev_q  <= ss;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign fifo_re = fifo_re_q & {N_CH{~ss}};
    assign tx_data = tx_q;
    assign ctrl    = ctrl_q;
    assign busy    = busy_q;

`ifdef SPI_BRIDGE_POPCNT_EN
    logic [15:0] popcnt_q, popcnt_d;
    logic        popcnt_clr;

    // Second STATUS data word has just been shifted out.
    assign popcnt_clr = respond && !first_word && (opcode == c_op_status) && (data_cnt_q == 2'd1);

    always_comb begin
        popcnt_d = popcnt_q;
        if (popcnt_clr) begin
            popcnt_d = '0;
        end else if ((|fifo_re) && (popcnt_q != 16'hFFFF)) begin
            popcnt_d = popcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            popcnt_q <= '0;
        end else begin
            popcnt_q <= popcnt_d;
        end
    end

    assign status_w2 = DW'(popcnt_q);
`else
    assign status_w2 = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_bridge.sv
//-----------------------------------------------------------------------------
// Module   : tb_spi_cmd_bridge
// Brief    : Self-checking bench for spi_cmd_bridge with FIFO and master models.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_spi_cmd_bridge;

    localparam int DW   = 16;
    localparam int N_CH = 2;

    typedef logic [15:0] wvec_t [8];

    logic                clk = 1'b0;
    logic                rst_n;
    logic                ss;
    logic                spi_done;
    logic [DW-1:0]       rx_data;
    logic [DW-1:0]       tx_data;
    logic [N_CH-1:0]     fifo_empty;
    logic [N_CH*DW-1:0]  fifo_rdata;
    logic [N_CH-1:0]     fifo_re;
    logic [DW-1:0]       ctrl;
    logic                busy;

    int n_vec = 0;
    int n_err = 0;

    // Hardware-side FIFO storage
    logic [15:0] fmem   [N_CH][256];
    logic [7:0]  rd_ptr [N_CH] = '{default: 8'd0};
    logic [7:0]  wr_ptr [N_CH] = '{default: 8'd0};
    int          re_cnt [N_CH] = '{default: 0};
    int          multi_hot   = 0;
    int          re_while_ss = 0;

    // Reference model state
    logic [15:0] mq     [N_CH][$];
    int          pops_m [N_CH] = '{default: 0};
    logic [15:0] ctrl_m = 16'h0000;
`ifdef SPI_BRIDGE_POPCNT_EN
    logic [15:0] popcnt_m = 16'h0000;
`endif

    always #5 clk = ~clk;

    spi_cmd_bridge #(
        .DW   (DW),
        .N_CH (N_CH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss         (ss),
        .spi_done   (spi_done),
        .rx_data    (rx_data),
        .tx_data    (tx_data),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_re    (fifo_re),
        .ctrl       (ctrl),
        .busy       (busy)
    );

    for (genvar k = 0; k < N_CH; k++) begin : g_fifo
        assign fifo_empty[k]          = (rd_ptr[k] == wr_ptr[k]);
        assign fifo_rdata[k*DW +: DW] = fmem[k][rd_ptr[k]];
    end

    always @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (fifo_re[k] === 1'b1) begin
                rd_ptr[k] <= rd_ptr[k] + 8'd1;
                re_cnt[k] = re_cnt[k] + 1;
            end
        end
        if ($countones(fifo_re) > 1) multi_hot = multi_hot + 1;
        if ((|fifo_re) && ss) re_while_ss = re_while_ss + 1;
    end

    task automatic push(input int c, input logic [15:0] v);
        fmem[c][wr_ptr[c]] = v;
        wr_ptr[c] = wr_ptr[c] + 8'd1;
        mq[c].push_back(v);
    endtask

    // One SPI word: the master sees tx_data before the word, then done pulses.
    task automatic word(input logic [15:0] d, output logic [15:0] seen);
        @(negedge clk);
        seen    = tx_data;
        rx_data = d;
        repeat (2) @(negedge clk);
        spi_done = 1'b1;
        repeat (2) @(negedge clk);
        spi_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_txn(input wvec_t w, input int n, output wvec_t seen, output logic busy_seen);
        seen = '{default: 16'h0000};
        ss = 1'b0;
        repeat (3) @(negedge clk);
        busy_seen = busy;
        for (int i = 0; i <= n; i++) begin
            word(w[i], seen[i]);
        end
        ss = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Expected words read by the master: word i+1 carries the response to the done of word i.
    task automatic model_txn(input wvec_t w, input int n, output wvec_t e);
        logic [7:0]  op;
        int          c;
        logic [15:0] nxt;
        op = w[0][15:8];
        c  = int'(w[0][7:0]);
        e  = '{default: 16'h0000};
        e[0] = 16'hFFFF;
        for (int i = 0; i <= n; i++) begin
            case (op)
                8'h01: begin
                    if (c < N_CH && mq[c].size() > 0) begin
                        nxt = mq[c].pop_front();
                        pops_m[c]++;
`ifdef SPI_BRIDGE_POPCNT_EN
                        if (popcnt_m != 16'hFFFF) popcnt_m = popcnt_m + 16'd1;
`endif
                    end else begin
                        nxt = 16'hFFFF;
                    end
                end
                8'h02: begin
                    nxt = 16'h0000;
                    if (i == 0) begin
                        for (int k = 0; k < N_CH; k++) nxt[k] = (mq[k].size() == 0);
                    end
`ifdef SPI_BRIDGE_POPCNT_EN
                    else if (i == 1) nxt = popcnt_m;
                    if (i == 2) popcnt_m = 16'h0000;
`endif
                end
                8'h03: begin
                    if (i == 1) ctrl_m = w[1];
                    nxt = ctrl_m;
                end
                8'hFF:   nxt = 16'hFFFF;
                default: nxt = 16'hDEAD;
            endcase
            if (i < n) e[i+1] = nxt;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ss = 1'b1; spi_done = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (tx_data !== 16'hFFFF) begin n_err++; $display("FAIL reset tx_data: got %h want ffff", tx_data); end
        n_vec++; if (ctrl !== 16'h0000)    begin n_err++; $display("FAIL reset ctrl: got %h want 0000", ctrl); end
        n_vec++; if (fifo_re !== 2'b00)    begin n_err++; $display("FAIL reset fifo_re: got %b want 00", fifo_re); end
        n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fifo_rd();
        wvec_t w, e, s; logic b; int r0, r1;
        push(1, 16'h00A1); push(1, 16'h00A2);
        w = '{default: 16'h0000};
        w[0] = 16'h0101;
        for (int i = 1; i <= 3; i++) w[i] = 16'($urandom);
        r0 = re_cnt[0]; r1 = re_cnt[1];
        model_txn(w, 3, e);
        run_txn(w, 3, s, b);
        for (int i = 0; i <= 3; i++) begin
            n_vec++; if (s[i] !== e[i]) begin n_err++; $display("FAIL fifo_rd word%0d: got %h want %h", i, s[i], e[i]); end
        end
        n_vec++; if (b !== 1'b1) begin n_err++; $display("FAIL fifo_rd busy: got %b want 1", b); end
        n_vec++; if (re_cnt[1] - r1 !== 2) begin n_err++; $display("FAIL fifo_rd pops ch1: got %0d want 2", re_cnt[1] - r1); end
        n_vec++; if (re_cnt[0] - r0 !== 0) begin n_err++; $display("FAIL fifo_rd pops ch0: got %0d want 0", re_cnt[0] - r0); end
    endtask

    task automatic test_invalid_ch();
        wvec_t w, e, s; logic b; int r;
        logic [15:0] cmds [2];
        cmds[0] = 16'h0105; cmds[1] = 16'h01FF;
        push(0, 16'h1234); push(1, 16'h5678);
        for (int t = 0; t < 2; t++) begin
            w = '{default: 16'h0000};
            w[0] = cmds[t];
            r = re_cnt[0] + re_cnt[1];
            model_txn(w, 3, e);
            run_txn(w, 3, s, b);
            for (int i = 1; i <= 3; i++) begin
                n_vec++; if (s[i] !== e[i]) begin n_err++; $display("FAIL invalid_ch %h word%0d: got %h want %h", cmds[t], i, s[i], e[i]); end
            end
            n_vec++; if (re_cnt[0] + re_cnt[1] - r !== 0) begin n_err++; $display("FAIL invalid_ch %h pops: got %0d want 0", cmds[t], re_cnt[0] + re_cnt[1] - r); end
        end
    endtask

    task automatic test_ctrl_wr();
        wvec_t w, e, s; logic b;
        w = '{default: 16'h0000};
        w[0] = 16'h0300; w[1] = 16'h0001; w[2] = 16'h0000;
        model_txn(w, 2, e);
        run_txn(w, 2, s, b);
        for (int i = 0; i <= 2; i++) begin
            n_vec++; if (s[i] !== e[i]) begin n_err++; $display("FAIL ctrl_wr word%0d: got %h want %h", i, s[i], e[i]); end
        end
        n_vec++; if (ctrl !== ctrl_m) begin n_err++; $display("FAIL ctrl_wr ctrl: got %h want %h", ctrl, ctrl_m); end
        n_vec++; if (ctrl !== 16'h0001) begin n_err++; $display("FAIL ctrl_wr ctrl value: got %h want 0001", ctrl); end
    endtask

    task automatic test_ss_truncate();
        wvec_t w, e, s; logic b; logic [15:0] s0, s1, head; int r;
        push(1, 16'h5A01); push(1, 16'h5A02);
        w = '{default: 16'h0000};
        w[0] = 16'h0101;
        head = (mq[1].size() > 0) ? mq[1][0] : 16'hFFFF;
        model_txn(w, 0, e);
        r = re_cnt[1];
        ss = 1'b0;
        repeat (3) @(negedge clk);
        word(16'h0101, s0);
        @(negedge clk);
        s1 = tx_data;
        rx_data  = 16'($urandom);
        spi_done = 1'b1;
        ss       = 1'b1;
        repeat (3) @(negedge clk);
        spi_done = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (s1 !== head) begin n_err++; $display("FAIL truncate word1: got %h want %h", s1, head); end
        n_vec++; if (re_cnt[1] - r !== 1) begin n_err++; $display("FAIL truncate pops: got %0d want 1", re_cnt[1] - r); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL truncate busy: got %b want 0", busy); end
        n_vec++; if (tx_data !== 16'hFFFF) begin n_err++; $display("FAIL truncate tx_data: got %h want ffff", tx_data); end
        model_txn(w, 2, e);
        run_txn(w, 2, s, b);
        for (int i = 1; i <= 2; i++) begin
            n_vec++; if (s[i] !== e[i]) begin n_err++; $display("FAIL truncate reread word%0d: got %h want %h", i, s[i], e[i]); end
        end
    endtask

    task automatic test_status();
        wvec_t w, e, s; logic b;
        for (int i = 0; i < 3; i++) push(0, 16'($urandom));
        w = '{default: 16'h0000};
        w[0] = 16'h0100;
        model_txn(w, 2, e);
        run_txn(w, 2, s, b);
        for (int t = 0; t < 2; t++) begin
            w = '{default: 16'h0000};
            w[0] = 16'h0200;
            model_txn(w, 3, e);
            run_txn(w, 3, s, b);
            for (int i = 1; i <= 3; i++) begin
                n_vec++; if (s[i] !== e[i]) begin n_err++; $display("FAIL status pass%0d word%0d: got %h want %h", t, i, s[i], e[i]); end
            end
        end
    endtask

    task automatic test_other_ops();
        wvec_t w, e, s; logic b;
        logic [15:0] cmds [2];
        cmds[0] = 16'hFF00;
        cmds[1] = {8'h10 + 8'($urandom_range(0, 96)), 8'($urandom)};
        for (int t = 0; t < 2; t++) begin
            w = '{default: 16'h0000};
            w[0] = cmds[t]; w[1] = 16'($urandom); w[2] = 16'($urandom);
            model_txn(w, 2, e);
            run_txn(w, 2, s, b);
            for (int i = 1; i <= 2; i++) begin
                n_vec++; if (s[i] !== e[i]) begin n_err++; $display("FAIL op %h word%0d: got %h want %h", cmds[t], i, s[i], e[i]); end
            end
        end
        n_vec++; if (ctrl !== ctrl_m) begin n_err++; $display("FAIL other_ops ctrl: got %h want %h", ctrl, ctrl_m); end
    endtask

    task automatic test_async_reset();
        wvec_t w, e, s; logic b; logic [15:0] d; int r;
        w = '{default: 16'h0000};
        w[0] = 16'h0300; w[1] = 16'h00F0;
        model_txn(w, 1, e);
        run_txn(w, 1, s, b);
        push(0, 16'hC0DE);
        w[0] = 16'h0100;
        model_txn(w, 0, e);
        ss = 1'b0;
        repeat (3) @(negedge clk);
        word(16'h0100, d);
        rst_n = 1'b0;
        #1;
        n_vec++; if (tx_data !== 16'hFFFF) begin n_err++; $display("FAIL async_reset tx_data: got %h want ffff", tx_data); end
        n_vec++; if (ctrl !== 16'h0000) begin n_err++; $display("FAIL async_reset ctrl: got %h want 0000", ctrl); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_reset busy: got %b want 0", busy); end
        ctrl_m = 16'h0000;
`ifdef SPI_BRIDGE_POPCNT_EN
        popcnt_m = 16'h0000;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        push(1, 16'hBEEF);
        r = re_cnt[0] + re_cnt[1];
        word(16'h0101, d);
        word(16'h0000, d);
        n_vec++; if (re_cnt[0] + re_cnt[1] - r !== 0) begin n_err++; $display("FAIL async_reset resync pops: got %0d want 0", re_cnt[0] + re_cnt[1] - r); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_reset resync busy: got %b want 0", busy); end
        ss = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        wvec_t w, e, s; logic b; int n; logic [7:0] op;
        for (int t = 0; t < 40; t++) begin
            for (int p = 0; p < int'($urandom_range(0, 3)); p++) push(int'($urandom_range(0, N_CH - 1)), 16'($urandom));
            case ($urandom_range(0, 5))
                0:       op = 8'h01;
                1:       op = 8'h02;
                2:       op = 8'h03;
                3:       op = 8'hFF;
                default: op = 8'h10 + 8'($urandom_range(0, 96));
            endcase
            n = int'($urandom_range(0, 5));
            w = '{default: 16'h0000};
            w[0] = {op, 8'($urandom_range(0, 3))};
            for (int i = 1; i <= n; i++) w[i] = 16'($urandom);
            model_txn(w, n, e);
            run_txn(w, n, s, b);
            for (int i = 0; i <= n; i++) begin
                n_vec++; if (s[i] !== e[i]) begin n_err++; $display("FAIL random t%0d cmd %h word%0d: got %h want %h", t, w[0], i, s[i], e[i]); end
            end
            n_vec++; if (b !== 1'b1) begin n_err++; $display("FAIL random t%0d busy: got %b want 1", t, b); end
            n_vec++; if (ctrl !== ctrl_m) begin n_err++; $display("FAIL random t%0d ctrl: got %h want %h", t, ctrl, ctrl_m); end
            for (int k = 0; k < N_CH; k++) begin
                n_vec++; if (re_cnt[k] !== pops_m[k]) begin n_err++; $display("FAIL random t%0d pops ch%0d: got %0d want %0d", t, k, re_cnt[k], pops_m[k]); end
            end
        end
    endtask

    task automatic test_invariants();
        n_vec++; if (multi_hot !== 0) begin n_err++; $display("FAIL invariant onehot: got %0d multi-hot clks want 0", multi_hot); end
        n_vec++; if (re_while_ss !== 0) begin n_err++; $display("FAIL invariant re_while_ss: got %0d want 0", re_while_ss); end
        for (int k = 0; k < N_CH; k++) begin
            n_vec++;
            if (int'(8'(wr_ptr[k] - rd_ptr[k])) !== mq[k].size()) begin
                n_err++;
                $display("FAIL invariant fifo%0d level: got %0d want %0d", k, int'(8'(wr_ptr[k] - rd_ptr[k])), mq[k].size());
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fifo_rd();
        test_invalid_ch();
        test_ctrl_wr();
        test_ss_truncate();
        test_status();
        test_other_ops();
        test_async_reset();
        test_random();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
